// File: rtl/alu_issue_sequencer.sv
// Round-robin issue sequencer for the shared combinational ALU: registers operands,
// waits a per-opcode settle window, captures the 64-bit result into zhi/zlo, then responds.
module alu_issue_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  output logic        alu_add,
  input  logic [63:0] alu_result,
  output logic [31:0] zhi,
  output logic [31:0] zlo,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        done_id,
  output logic        done_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold valid and payload until accepted; the response holds until done_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_opcode;
  logic [31:0] r_zhi;
  logic [31:0] r_zlo;
  logic        r_id;
  logic        r_err;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [4:0]  w_sel_opcode;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [3:0]  w_sel_last;
  logic        w_sel_legal;

  // The port that did not win last time has priority when both are valid.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (clear_n && (r_state == S_IDLE)) begin
      w_grant0 = req0_valid && (!req1_valid || r_last_grant);
      w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    end
  end

  assign w_accept     = w_grant0 || w_grant1;
  assign w_sel_opcode = w_grant1 ? req1_opcode : req0_opcode;
  assign w_sel_a      = w_grant1 ? req1_a : req0_a;
  assign w_sel_b      = w_grant1 ? req1_b : req0_b;
  assign w_sel_legal  = (w_sel_opcode >= 5'b00011) && (w_sel_opcode <= 5'b10010);

  always_comb begin
    w_sel_last = 4'd0;
    if (w_sel_opcode == OP_MUL) begin
      w_sel_last = MUL_LAST;
    end else if (w_sel_opcode == OP_DIV) begin
      w_sel_last = DIV_LAST;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_EXEC;
      S_EXEC: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: if (done_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_opcode     <= 5'd0;
      r_zhi        <= 32'd0;
      r_zlo        <= 32'd0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_opcode     <= w_sel_opcode;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
        r_err        <= !w_sel_legal;
        r_cnt        <= w_sel_last;
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == 4'd0) begin
          // An illegal opcode produces a zero result regardless of what the ALU drives.
          r_zhi <= r_err ? 32'd0 : alu_result[63:32];
          r_zlo <= r_err ? 32'd0 : alu_result[31:0];
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_opcode;
  assign alu_add    = 1'b0;
  assign zhi        = r_zhi;
  assign zlo        = r_zlo;
  assign done_valid = (r_state == S_RESP);
  assign done_id    = r_id;
  assign done_err   = r_err;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: an ALU stand-in that returns garbage until its operands
// have settled, a timeline model of the sequencer, and directed scenarios with literal checks.
module tb_alu_issue_sequencer;

  localparam int MUL_C = 4;
  localparam int DIV_C = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_opcode = 5'd0;
  logic [31:0] req0_a = 32'd0;
  logic [31:0] req0_b = 32'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_opcode = 5'd0;
  logic [31:0] req1_a = 32'd0;
  logic [31:0] req1_b = 32'd0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic        alu_add;
  logic [63:0] alu_result;
  logic [31:0] zhi;
  logic [31:0] zlo;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic        done_id;
  logic        done_err;
  logic        busy;
  logic [1:0]  dbg_state;

  alu_issue_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clock(clock), .clear_n(clear_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_add(alu_add),
    .alu_result(alu_result), .zhi(zhi), .zlo(zlo),
    .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
    .done_err(done_err), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit is_legal(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd18);
  endfunction

  function automatic int lat(input logic [4:0] op);
    if (op == 5'd15) return MUL_C;
    if (op == 5'd16) return DIV_C;
    return 1;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] s;
    case (op)
      5'd3:  begin s = a + b; return {32'd0, s}; end
      5'd4:  begin s = a - b; return {32'd0, s}; end
      5'd5:  return {32'd0, a & b};
      5'd6:  return {32'd0, a | b};
      5'd15: return {32'd0, a} * {32'd0, b};
      5'd16: return (b != 0) ? {a % b, a / b} : 64'd0;
      default: return is_legal(op) ? {32'd0, a ^ b} : 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // ALU stand-in: result is only correct once operands have been held for L cycles.
  int settle = 15;
  int grant_log[$];
  always @(posedge clock) begin
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) settle <= 0;
    else if (settle < 15) settle <= settle + 1;
    if (req0_valid && req0_ready) grant_log.push_back(0);
    if (req1_valid && req1_ready) grant_log.push_back(1);
  end
  assign alu_result = (settle >= lat(alu_opcode) - 1) ? ref_alu(alu_opcode, alu_a, alu_b)
                                                      : 64'hA5A5_A5A5_5A5A_5A5A;

  // ---------------- timeline model ----------------
  bit          m_active = 1'b0;
  bit          m_last = 1'b1;
  bit          m_id = 1'b0;
  bit          m_err = 1'b0;
  logic [63:0] m_z = 64'd0;
  logic [63:0] m_exp = 64'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [4:0]  m_op = 5'd0;
  longint      m_cyc = 0;
  longint      m_t_resp = 0;

  function automatic bit exp_ready(input int port);
    if (!clear_n || m_active) return 1'b0;
    if (port == 0) return req0_valid && (!req1_valid || m_last);
    return req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(posedge clock) begin
    bit dv, g0, g1;
    dv = m_active && (m_cyc >= m_t_resp);
    g0 = exp_ready(0);
    g1 = exp_ready(1);
    if (!clear_n) begin
      m_active = 1'b0; m_last = 1'b1; m_id = 1'b0; m_err = 1'b0;
      m_z = 64'd0; m_a = 32'd0; m_b = 32'd0; m_op = 5'd0;
    end else if (dv && done_ready) begin
      m_active = 1'b0;
    end else if (g0 || g1) begin
      m_op  = g1 ? req1_opcode : req0_opcode;
      m_a   = g1 ? req1_a : req0_a;
      m_b   = g1 ? req1_b : req0_b;
      m_id  = g1;
      m_last = g1;
      m_err = !is_legal(m_op);
      m_exp = m_err ? 64'd0 : ref_alu(m_op, m_a, m_b);
      m_t_resp = m_cyc + 1 + lat(m_op);
      m_active = 1'b1;
    end
    m_cyc++;
    if (clear_n && m_active && (m_cyc == m_t_resp)) m_z = m_exp;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      chk("req0_ready", req0_ready, exp_ready(0));
      chk("req1_ready", req1_ready, exp_ready(1));
      chk("busy", busy, m_active);
      chk("done_valid", done_valid, m_active && (m_cyc >= m_t_resp));
      chk("done_id", done_id, m_id);
      chk("done_err", done_err, m_err);
      chk("zhi", zhi, m_z[63:32]);
      chk("zlo", zlo, m_z[31:0]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_add", alu_add, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic send(input int port, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    bit got = 1'b0;
    @(negedge clock);
    if (port == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      got = (port == 0) ? req0_ready : req1_ready;
      @(posedge clock);
      if (!got) @(negedge clock);
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(negedge clock);
    if (port == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Called at the negedge of the first EXEC cycle; counts EXEC cycles until done_valid.
  task automatic wait_done(input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      #3;
      if (done_valid) seen = 1'b1;
      else begin
        n++;
        @(negedge clock);
      end
    end
    chk("done_seen", seen, 1);
    chk("exec_cycles", n, exp_lat);
  endtask

  task automatic finish_resp(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      req0_valid = 1'b1; req0_opcode = 5'd3; req0_a = 32'd1; req0_b = 32'd1;
      #3;
      chk("hold_done_valid", done_valid, 1);
      chk("hold_req0_ready", req0_ready, 0);
      chk("hold_zlo", zlo, 32'd14);
    end
    if (hold > 0) begin
      @(negedge clock);
      req0_valid = 1'b0;
      done_ready = 1'b1;
    end
    @(negedge clock);
    #3;
    chk("busy_after_handshake", busy, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    @(negedge clock);
    req0_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    #3;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_zlo", zlo, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    req0_valid = 1'b0;
    clear_n = 1'b1;

    // ADD 5+7 from req0
    send(0, 5'b00011, 32'd5, 32'd7);
    wait_done(1);
    chk("add_zlo", zlo, 32'd12);
    chk("add_zhi", zhi, 32'd0);
    chk("add_id", done_id, 0);
    chk("add_err", done_err, 0);
    finish_resp(0);

    // MUL 6*7 from req1
    send(1, 5'b01111, 32'd6, 32'd7);
    wait_done(MUL_C);
    chk("mul_zlo", zlo, 32'd42);
    chk("mul_zhi", zhi, 32'd0);
    chk("mul_id", done_id, 1);
    finish_resp(0);

    // Both requesters held valid right after reset
    do_reset();
    grant_log.delete();
    fork
      begin send(0, 5'b00100, 32'd9, 32'd4); send(0, 5'b00100, 32'd9, 32'd4); end
      begin send(1, 5'b00110, 32'hF0, 32'h0F); send(1, 5'b00110, 32'hF0, 32'h0F); end
    join
    wait_idle();
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("rr_g0", grant_log[0], 0);
      chk("rr_g1", grant_log[1], 1);
      chk("rr_g2", grant_log[2], 0);
      chk("rr_g3", grant_log[3], 1);
    end
    chk("rr_last_zlo", zlo, 32'hFF);
    chk("rr_last_id", done_id, 1);

    // DIV 100/7 with a back-pressured response
    done_ready = 1'b0;
    send(0, 5'b10000, 32'd100, 32'd7);
    wait_done(DIV_C);
    chk("div_zlo", zlo, 32'd14);
    chk("div_zhi", zhi, 32'd2);
    chk("div_id", done_id, 0);
    finish_resp(3);

    // Reset in the third EXEC cycle of a DIV
    send(1, 5'b10000, 32'd50, 32'd3);
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    #3;
    chk("abort_zhi", zhi, 0);
    chk("abort_zlo", zlo, 0);
    chk("abort_done_valid", done_valid, 0);
    chk("abort_busy", busy, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #0;
    chk("abort_first_req0", req0_ready, 1);
    chk("abort_first_req1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Illegal opcode, then a legal one
    send(1, 5'b11111, 32'd9, 32'd9);
    wait_done(1);
    chk("ill_zhi", zhi, 0);
    chk("ill_zlo", zlo, 0);
    chk("ill_err", done_err, 1);
    chk("ill_id", done_id, 1);
    finish_resp(0);
    send(0, 5'b00011, 32'd1, 32'd1);
    wait_done(1);
    chk("after_ill_zlo", zlo, 32'd2);
    chk("after_ill_err", done_err, 0);
    finish_resp(0);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
